sram1: RTL and testbench
========================

// Module: sram1
// PURPOSE
//   On-chip 96 KiB single-port word SRAM ("SRAM1") mapped at 0x2000_0000-0x2001_7FFF of the 32-bit address space.
//   Serves one 32-bit read or write per clock for the core's data bus.
//   Accesses outside the window are ignored; reads outside the window return zero.
// PARAMETERS
//   BASE_ADDR   32'h2000_0000  first byte address of the window
//   SIZE_BYTES  32'h0001_8000  window size in bytes (98304); must be a multiple of 4
//   DATA_WIDTH  32             word width; address width is fixed at 32
// PORTS
//   clock       in   1   system clock; all state updates on the rising edge
//   reset       in   1   synchronous, active-high reset
//   read_write  in   1   1 = write cycle, 0 = read cycle
//   address     in   32  byte address
//   data_in     in   32  write data; sampled only when read_write=1
//   data_out    out  32  registered read data
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset (reset=1 at a rising edge):
//     - data_out <= 0.
//     - Array contents are NOT cleared and are undefined after power-up.
//     - Any write presented in the same cycle is discarded.
//   - in_range = (address >= BASE_ADDR) && (address <= BASE_ADDR+SIZE_BYTES-1).
//     - Compare on the full 32 bits with no wrap-around.
//   - Word index = (address - BASE_ADDR) >> 2; the low 2 address bits are ignored.
//     - Every access is a full aligned word.
//     - 0x2001_7FFF therefore maps to the word at 0x2001_7FFC.
//   - Write (read_write=1, in_range):
//     - mem[index] <= data_in at the rising edge.
//     - data_out holds its previous value.
//   - Write out of range: no array change; data_out holds its previous value.
//   - Read (read_write=0, in_range):
//     - data_out <= mem[index] at the rising edge.
//     - Latency is 1 clock: the value is valid after the edge that samples the address.
//   - Read out of range: data_out <= 32'h0000_0000.
//   - A read of a word written on the previous edge returns the new data (no stale read).
//   - There is no handshake or wait state; every cycle is an access.
//   - No byte or halfword enables; no error/abort output.
//   - The array is 24576 x 32. Implement it as an inferable synchronous RAM plus registered output mux.
// TESTING
//   - Write 0x01234567 @0x2000_0000, then read @0x2000_0000 with data_in=0x11111111
//     -> data_out=0x01234567 one edge later.
//   - Write 0xFEDCBA90 @0x2001_8000 (first byte past end), then read it
//     -> data_out=0x00000000; no in-range word altered.
//   - Write 0x89ABCDEF @0x2001_7FFF, then read @0x2001_7FFF
//     -> 0x89ABCDEF; a read @0x2001_7FFC also gives 0x89ABCDEF.
//   - Write 0x55555555 @0x1FFF_FFFC (below base), then read @0x1FFF_FFFF
//     -> 0x00000000.
//   - Read 0x01234567 @0x2000_0000, then assert reset for 1 cycle
//     -> data_out=0; a following read @0x2000_0000 still returns 0x01234567.
//   - Write-then-write-then-read the same word, 0xAAAA0000 then 0x0000BBBB
//     -> the read returns 0x0000BBBB; data_out is unchanged during both write cycles.

Source files
------------

// File: rtl/sram1.sv
// 96 KiB single-port word SRAM window on the 32-bit data bus.
// One full-word access per clock; registered read data, zero for reads outside the window.
module sram1 #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [31:0] SIZE_BYTES = 32'h0001_8000,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int WORDS = int'(SIZE_BYTES >> 2);
  localparam int IDX_W = $clog2(WORDS);

  logic [31:0]           offset;
  logic                  in_range;
  logic                  wr_en;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] mem [WORDS];

  // The lower-bound test guarantees the subtraction cannot wrap, so the
  // offset compare is equivalent to address <= BASE_ADDR + SIZE_BYTES - 1.
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) && (offset < SIZE_BYTES);
  assign word_idx = offset[IDX_W+1:2];
  assign wr_en    = !reset && read_write && in_range;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[word_idx] <= data_in;
    end
  end

  // Output register: cleared by reset, held across write cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
    end else if (!read_write) begin
      data_out <= in_range ? mem[word_idx] : '0;
    end
  end

endmodule

// File: tb/tb_sram1.sv
// Bench for sram1: directed vectors, a word-map reference model checked every
// cycle, and literal expectations after each directed step.
module tb_sram1;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] SIZE = 32'h0001_8000;

  logic        clock;
  logic        reset;
  logic        read_write;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int checks = 0;
  int passes = 0;

  sram1 dut (
    .clock     (clock),
    .reset     (reset),
    .read_write(read_write),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: word map keyed by aligned byte address.
  logic [31:0] mdl [longint];
  logic [31:0] exp_out;
  logic        exp_known = 1'b0;

  function automatic bit in_win(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la <= longint'(BASE) + longint'(SIZE) - 1);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      exp_out   <= 32'h0;
      exp_known <= 1'b1;
    end else if (read_write) begin
      if (in_win(address)) mdl[longint'(address & ~32'h3)] = data_in;
    end else if (!in_win(address)) begin
      exp_out <= 32'h0;
    end else if (mdl.exists(longint'(address & ~32'h3))) begin
      exp_out <= mdl[longint'(address & ~32'h3)];
    end else begin
      exp_known <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (exp_known) check("model", data_out, exp_out);
  end

  task automatic cyc(input logic rst, input logic rw, input logic [31:0] a, input logic [31:0] d);
    reset      = rst;
    read_write = rw;
    address    = a;
    data_in    = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    check("reset_out", data_out, 32'h0);

    cyc(1'b0, 1'b1, 32'h2000_0000, 32'h0123_4567);
    check("write_hold0", data_out, 32'h0);
    cyc(1'b0, 1'b0, 32'h2000_0000, 32'h1111_1111);
    check("read_base", data_out, 32'h0123_4567);

    cyc(1'b0, 1'b1, 32'h2001_8000, 32'hFEDC_BA90);
    check("oor_write_hold", data_out, 32'h0123_4567);
    cyc(1'b0, 1'b0, 32'h2001_8000, 32'h0);
    check("read_past_end", data_out, 32'h0);

    cyc(1'b0, 1'b1, 32'h2001_7FFF, 32'h89AB_CDEF);
    cyc(1'b0, 1'b0, 32'h2001_7FFF, 32'h0);
    check("read_last_byte", data_out, 32'h89AB_CDEF);
    cyc(1'b0, 1'b0, 32'h2001_7FFC, 32'h0);
    check("read_last_word", data_out, 32'h89AB_CDEF);
    cyc(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    check("base_intact", data_out, 32'h0123_4567);

    cyc(1'b0, 1'b0, 32'h2001_7FFC, 32'h0);
    cyc(1'b0, 1'b1, 32'h1FFF_FFFC, 32'h5555_5555);
    check("below_write_hold", data_out, 32'h89AB_CDEF);
    cyc(1'b0, 1'b0, 32'h1FFF_FFFF, 32'h0);
    check("read_below_base", data_out, 32'h0);

    cyc(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    check("read_before_rst", data_out, 32'h0123_4567);
    cyc(1'b1, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF);
    check("reset_clears_out", data_out, 32'h0);
    cyc(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    check("write_during_rst_dropped", data_out, 32'h0123_4567);

    cyc(1'b0, 1'b1, 32'h2000_0100, 32'hAAAA_0000);
    check("ww_hold1", data_out, 32'h0123_4567);
    cyc(1'b0, 1'b1, 32'h2000_0100, 32'h0000_BBBB);
    check("ww_hold2", data_out, 32'h0123_4567);
    cyc(1'b0, 1'b0, 32'h2000_0100, 32'h0);
    check("ww_read", data_out, 32'h0000_BBBB);
    cyc(1'b0, 1'b0, 32'h2000_0103, 32'h0);
    check("low_bits_ignored", data_out, 32'h0000_BBBB);

    cyc(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check("top_of_space", data_out, 32'h0);
    cyc(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    cyc(1'b0, 1'b0, 32'h0000_0000, 32'h0);
    check("addr_zero", data_out, 32'h0);

    // Distinct words across the window, then read them back in reverse.
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, BASE + 32'(i) * 32'h0000_3004, 32'hC0DE_0000 | 32'(i * 17));
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b0, BASE + 32'(i) * 32'h0000_3004 + 32'(i % 4), 32'h0);
      check("sweep", data_out, 32'hC0DE_0000 | 32'(i * 17));
    end

    @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
